// File: rtl/vsync_separator.sv
// -----------------------------------------------------------------------------
// vsync_separator
//   Recovers vertical sync from PAL composite sync. Low pulses on the
//   synchronised csync are classified as broad or short by width. A train of
//   BROAD_COUNT consecutive broad pulses asserts VSYNC. The block also reports
//   field identity, line count within the field and a lock flag.
//
// Ports
//   clk          in   system clock (100 MHz)
//   reset        in   asynchronous, active-high reset
//   comp_sync    in   raw composite sync, asynchronous (2-FF synchronised here)
//   hsync_in     in   reconstructed HSYNC, active low, clk domain
//   vsync_out    out  reconstructed VSYNC, active low
//   field_id     out  0 = field starts on a line boundary, 1 = starts mid-line
//   line_number  out  hsync falling edges since last VSYNC entry, saturating
//   locked       out  high after two consecutive fields with a valid line count
//
// Configuration
//   VSYNC_LINE_COUNT_EN  defined:   line counter built; lock needs the
//                                   LINES_MIN..LINES_MAX window on two fields.
//                        undefined: line_number tied to 0; lock sets on the
//                                   second VSYNC entry since reset/timeout.
// -----------------------------------------------------------------------------
module vsync_separator #(
    parameter int unsigned BROAD_MIN    = 2000,
    parameter int unsigned BROAD_COUNT  = 3,
    parameter int unsigned HALF_LINE    = 3200,
    parameter int unsigned EDGE_TIMEOUT = 8000,
    parameter int unsigned LINES_MIN    = 310,
    parameter int unsigned LINES_MAX    = 315
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       comp_sync,
    input  logic       hsync_in,
    output logic       vsync_out,
    output logic       field_id,
    output logic [9:0] line_number,
    output logic       locked
);

    localparam int unsigned WIDTH_W = 12;
    localparam int unsigned GAP_W   = 13;
    localparam int unsigned IDLE_W  = 13;
    localparam int unsigned LINE_W  = 10;
    localparam int unsigned BCNT_W  = 4;
    // An empty line window can never produce a valid field, so lock is withheld.
    localparam bit          WINDOW_VALID = (LINES_MIN <= LINES_MAX);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_VIDEO,
        ST_ARM,
        ST_VSYNC
    } state_t;

    // ---------------------------------------------------------------- state
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               csync_prev_q, csync_prev_d;
    logic               hsync_prev_q, hsync_prev_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   fall_gap_q, fall_gap_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    state_t             state_q, state_d;
    logic               vsync_q, vsync_d;
    logic               field_q, field_d;
    logic               locked_q, locked_d;
    logic               have_prev_q, have_prev_d;
    logic               ever_locked_q, ever_locked_d;
`ifdef VSYNC_LINE_COUNT_EN
    localparam int unsigned GOOD_W = 2;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [GOOD_W-1:0]  good_q, good_d;
`endif

    // ---------------------------------------------------------------- strobes
    logic              cs_fall_c;
    logic              cs_rise_c;
    logic              hs_fall_c;
    logic              is_broad_c;
    logic              entry_c;
    logic              timeout_c;
    logic [BCNT_W-1:0] bcnt_inc_c;

    // Next-state logic for all registers
    always_comb begin
        sync1_d       = comp_sync;
        sync2_d       = sync1_q;
        csync_prev_d  = sync2_q;
        hsync_prev_d  = hsync_in;
        width_d       = width_q;
        gap_d         = gap_q;
        fall_gap_d    = fall_gap_q;
        idle_d        = idle_q;
        bcnt_d        = bcnt_q;
        state_d       = state_q;
        vsync_d       = vsync_q;
        field_d       = field_q;
        locked_d      = locked_q;
        have_prev_d   = have_prev_q;
        ever_locked_d = ever_locked_q;
`ifdef VSYNC_LINE_COUNT_EN
        line_d        = line_q;
        good_d        = good_q;
`endif

        cs_fall_c  = csync_prev_q & ~sync2_q;
        cs_rise_c  = ~csync_prev_q & sync2_q;
        hs_fall_c  = hsync_prev_q & ~hsync_in;
        is_broad_c = (width_q >= WIDTH_W'(BROAD_MIN));
        bcnt_inc_c = bcnt_q + BCNT_W'(1);
        entry_c    = 1'b0;
        timeout_c  = 1'b0;

        // Low-pulse width; the falling-edge clear wins over the increment
        if (cs_fall_c) begin
            width_d = '0;
        end else if (!sync2_q && (width_q != {WIDTH_W{1'b1}})) begin
            width_d = width_q + WIDTH_W'(1);
        end

        // Distance from the last hsync; snapshot at each csync falling edge so
        // the broad pulse's start position is known when it is classified
        if (hs_fall_c) begin
            gap_d = '0;
        end else if (gap_q != {GAP_W{1'b1}}) begin
            gap_d = gap_q + GAP_W'(1);
        end
        if (cs_fall_c) begin
            fall_gap_d = gap_q;
        end

        // Cycles since last csync falling edge, held at the timeout value
        if (cs_fall_c) begin
            idle_d = '0;
        end else if (idle_q < IDLE_W'(EDGE_TIMEOUT)) begin
            idle_d = idle_q + IDLE_W'(1);
        end
        timeout_c = !cs_fall_c && (idle_q == IDLE_W'(EDGE_TIMEOUT - 1));

        // Pulse classification FSM, advanced on each csync rising edge
        if (cs_rise_c) begin
            case (state_q)
                ST_SEARCH: begin
                    if (is_broad_c) begin
                        bcnt_d  = BCNT_W'(1);
                        state_d = ST_ARM;
                    end
                end
                ST_VIDEO: begin
                    if (is_broad_c) begin
                        field_d = (fall_gap_q >= GAP_W'(HALF_LINE));
                        bcnt_d  = BCNT_W'(1);
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (is_broad_c) begin
                        bcnt_d = bcnt_inc_c;
                        if (bcnt_inc_c >= BCNT_W'(BROAD_COUNT)) begin
                            state_d = ST_VSYNC;
                            vsync_d = 1'b0;
                            entry_c = 1'b1;
                        end
                    end else begin
                        state_d = ever_locked_q ? ST_VIDEO : ST_SEARCH;
                    end
                end
                default: begin
                    if (!is_broad_c) begin
                        vsync_d = 1'b1;
                        state_d = ST_VIDEO;
                    end
                end
            endcase
        end

`ifdef VSYNC_LINE_COUNT_EN
        // Line counter; the VSYNC-entry clear wins over a coincident hsync
        if (entry_c) begin
            line_d = '0;
        end else if (hs_fall_c && (line_q != {LINE_W{1'b1}})) begin
            line_d = line_q + LINE_W'(1);
        end

        // Field-length check at VSYNC entry; the first entry has no prior field
        if (entry_c) begin
            have_prev_d = 1'b1;
            if (have_prev_q) begin
                if (WINDOW_VALID && (line_q >= LINE_W'(LINES_MIN)) &&
                    (line_q <= LINE_W'(LINES_MAX))) begin
                    if (good_q != GOOD_W'(2)) begin
                        good_d = good_q + GOOD_W'(1);
                    end
                    if (good_q != '0) begin
                        locked_d = 1'b1;
                    end
                end else begin
                    good_d   = '0;
                    locked_d = 1'b0;
                end
            end
        end
`else
        // Without a line count, the second VSYNC entry is enough to lock
        if (entry_c) begin
            have_prev_d = 1'b1;
            if (have_prev_q && WINDOW_VALID) begin
                locked_d = 1'b1;
            end
        end
`endif

        ever_locked_d = ever_locked_q | locked_d;

        // Loss of csync overrides everything; line count is left untouched
        if (timeout_c) begin
            state_d       = ST_SEARCH;
            vsync_d       = 1'b1;
            locked_d      = 1'b0;
            have_prev_d   = 1'b0;
            ever_locked_d = 1'b0;
            bcnt_d        = '0;
`ifdef VSYNC_LINE_COUNT_EN
            good_d        = '0;
`endif
        end
    end

    // State registers; csync synchroniser and hsync delay reset to idle-high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            csync_prev_q  <= 1'b1;
            hsync_prev_q  <= 1'b1;
            width_q       <= '0;
            gap_q         <= '0;
            fall_gap_q    <= '0;
            idle_q        <= '0;
            bcnt_q        <= '0;
            state_q       <= ST_SEARCH;
            vsync_q       <= 1'b1;
            field_q       <= 1'b0;
            locked_q      <= 1'b0;
            have_prev_q   <= 1'b0;
            ever_locked_q <= 1'b0;
`ifdef VSYNC_LINE_COUNT_EN
            line_q        <= '0;
            good_q        <= '0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            csync_prev_q  <= csync_prev_d;
            hsync_prev_q  <= hsync_prev_d;
            width_q       <= width_d;
            gap_q         <= gap_d;
            fall_gap_q    <= fall_gap_d;
            idle_q        <= idle_d;
            bcnt_q        <= bcnt_d;
            state_q       <= state_d;
            vsync_q       <= vsync_d;
            field_q       <= field_d;
            locked_q      <= locked_d;
            have_prev_q   <= have_prev_d;
            ever_locked_q <= ever_locked_d;
`ifdef VSYNC_LINE_COUNT_EN
            line_q        <= line_d;
            good_q        <= good_d;
`endif
        end
    end

    assign vsync_out = vsync_q;
    assign field_id  = field_q;
    assign locked    = locked_q;
`ifdef VSYNC_LINE_COUNT_EN
    assign line_number = line_q;
`else
    assign line_number = LINE_W'(0);
`endif

endmodule

// File: tb/tb_vsync_separator.sv
// -----------------------------------------------------------------------------
// tb_vsync_separator
//   Directed bench for vsync_separator on a time-scaled PAL raster (1 us ->
//   1 clk): 64-cycle lines built from 32-cycle half-line slots. hsync_in falls
//   on every even slot. Field 0 has its broad train starting on a line
//   boundary, field 1 starts it mid-line.
// -----------------------------------------------------------------------------
module tb_vsync_separator;

    localparam int unsigned T_BROAD_MIN    = 20;
    localparam int unsigned T_BROAD_COUNT  = 3;
    localparam int unsigned T_HALF_LINE    = 32;
    localparam int unsigned T_EDGE_TIMEOUT = 80;
    localparam int unsigned T_LINES_MIN    = 20;
    localparam int unsigned T_LINES_MAX    = 24;

    localparam int SLOT      = 32;
    localparam int EQ_LOW    = 2;
    localparam int BROAD_LOW = 27;
    localparam int HS_LOW    = 5;
    localparam int L_GOOD    = 22;
    localparam int L_SHORT   = 14;

    localparam int K_NONE  = 0;
    localparam int K_LINE  = 1;
    localparam int K_EQ    = 2;
    localparam int K_BROAD = 3;

    localparam int M_SEARCH = 0;
    localparam int M_VIDEO  = 1;
    localparam int M_ARM    = 2;
    localparam int M_VSYNC  = 3;

    logic       clk;
    logic       reset;
    logic       comp_sync;
    logic       hsync_in;
    logic       vsync_out;
    logic       field_id;
    logic [9:0] line_number;
    logic       locked;

    vsync_separator #(
        .BROAD_MIN    (T_BROAD_MIN),
        .BROAD_COUNT  (T_BROAD_COUNT),
        .HALF_LINE    (T_HALF_LINE),
        .EDGE_TIMEOUT (T_EDGE_TIMEOUT),
        .LINES_MIN    (T_LINES_MIN),
        .LINES_MAX    (T_LINES_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .comp_sync   (comp_sync),
        .hsync_in    (hsync_in),
        .vsync_out   (vsync_out),
        .field_id    (field_id),
        .line_number (line_number),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pulse-level reference state
    int m_state;
    int m_bcnt;
    int m_good;
    int hs_cnt;
    bit m_have_prev;
    bit m_locked;
    bit m_ever;
    bit m_field;
    int cur_ftype;

    // Per-slot observations
    int vs_fall_i;
    int vs_rise_i;
    int ln_mid;
    bit vs_low_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic cs, input logic hs);
        comp_sync = cs;
        hsync_in  = hs;
        @(posedge clk);
        #1;
    endtask

    // One half-line slot; records the tick index of any vsync_out edge
    task automatic slot(input int kind, input bit hs);
        int   low;
        logic prev;
        case (kind)
            K_LINE:  low = HS_LOW;
            K_EQ:    low = EQ_LOW;
            K_BROAD: low = BROAD_LOW;
            default: low = 0;
        endcase
        prev      = vsync_out;
        vs_fall_i = -1;
        vs_rise_i = -1;
        if (hs && hs_cnt < 1023) hs_cnt++;
        for (int i = 0; i < SLOT; i++) begin
            tick((i < low) ? 1'b0 : 1'b1, (hs && i < HS_LOW) ? 1'b0 : 1'b1);
            if (i == 20) ln_mid = int'(line_number);
            if (vsync_out !== prev) begin
                if (vsync_out === 1'b0 && vs_fall_i < 0) vs_fall_i = i;
                if (vsync_out === 1'b1 && vs_rise_i < 0) vs_rise_i = i;
                prev = vsync_out;
            end
            if (vsync_out === 1'b0) vs_low_seen = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_state     = M_SEARCH;
        m_bcnt      = 0;
        m_good      = 0;
        hs_cnt      = 0;
        m_have_prev = 1'b0;
        m_locked    = 1'b0;
        m_ever      = 1'b0;
        m_field     = 1'b0;
    endtask

    task automatic model_entry();
`ifdef VSYNC_LINE_COUNT_EN
        check("ln_before_clear", ln_mid, hs_cnt);
`else
        check("ln_before_clear", ln_mid, 0);
`endif
        check("vs_fall_tick", vs_fall_i, BROAD_LOW + 2);
        check("ln_after_clear", line_number, 0);
        if (m_have_prev) begin
`ifdef VSYNC_LINE_COUNT_EN
            if (hs_cnt >= int'(T_LINES_MIN) && hs_cnt <= int'(T_LINES_MAX)) begin
                if (m_good < 2) m_good++;
                if (m_good == 2) m_locked = 1'b1;
            end else begin
                m_good   = 0;
                m_locked = 1'b0;
            end
`else
            m_locked = 1'b1;
`endif
        end
        m_have_prev = 1'b1;
        if (m_locked) m_ever = 1'b1;
        check("locked_at_entry", locked, m_locked);
        hs_cnt  = 0;
        m_state = M_VSYNC;
    endtask

    task automatic model_pulse(input int kind);
        bit broad;
        broad = (kind == K_BROAD);
        if (kind != K_NONE) begin
            case (m_state)
                M_SEARCH: if (broad) begin
                    m_bcnt  = 1;
                    m_state = M_ARM;
                end
                M_VIDEO: if (broad) begin
                    m_field = cur_ftype[0];
                    m_bcnt  = 1;
                    m_state = M_ARM;
                end
                M_ARM: if (broad) begin
                    m_bcnt++;
                    if (m_bcnt == int'(T_BROAD_COUNT)) model_entry();
                end else begin
                    check("arm_abort_no_vs", vs_fall_i, -1);
                    m_state = m_ever ? M_VIDEO : M_SEARCH;
                end
                default: if (broad) begin
                    check("vs_hold_low", vsync_out, 0);
                end else begin
                    check("vs_rise_tick", vs_rise_i, EQ_LOW + 2);
                    m_state = M_VSYNC - 2;
                end
            endcase
        end
    endtask

    task automatic do_reset_mid();
        reset = 1'b1;
        #1;
        check("rstmid_vsync", vsync_out, 1);
        check("rstmid_field", field_id, 0);
        check("rstmid_line", line_number, 0);
        check("rstmid_locked", locked, 0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        reset = 1'b0;
        tick(1'b1, 1'b1);
        model_reset();
    endtask

    // One field: pre-eq, broad train, post-eq over 16 slots, then video lines
    task automatic run_field(input int ftype, input int lines, input int nbroad, input int rst_after);
        int pre;
        int kind;
        cur_ftype   = ftype;
        pre         = (ftype != 0) ? 5 : 6;
        vs_low_seen = 1'b0;
        for (int sl = 0; sl < 2 * lines; sl++) begin
            if (sl < pre)               kind = K_EQ;
            else if (sl < pre + nbroad) kind = K_BROAD;
            else if (sl < 16)           kind = K_EQ;
            else                        kind = (sl % 2 == 0) ? K_LINE : K_NONE;
            slot(kind, (sl % 2) == 0);
            model_pulse(kind);
            if (sl == rst_after) do_reset_mid();
        end
        if (nbroad < int'(T_BROAD_COUNT)) check("short_train_no_vs", vs_low_seen, 0);
        check("field_id", field_id, m_field);
        check("locked_end", locked, m_locked);
        check("vsync_end", vsync_out, 1);
    endtask

    initial begin
        reset     = 1'b1;
        comp_sync = 1'b1;
        hsync_in  = 1'b1;
        model_reset();
        #1;
        check("rst_vsync", vsync_out, 1);
        check("rst_field", field_id, 0);
        check("rst_line", line_number, 0);
        check("rst_locked", locked, 0);
        repeat (3) tick(1'b1, 1'b1);
        reset = 1'b0;
        repeat (3) tick(1'b1, 1'b1);

        // Acquire, then alternate fields while locked
        run_field(0, L_GOOD, 5, -1);
        run_field(1, L_GOOD, 5, -1);
        run_field(0, L_GOOD, 5, -1);
        for (int k = 0; k < 10; k++) run_field((k % 2 == 0) ? 1 : 0, L_GOOD, 5, -1);

        // Reset during VSYNC (after the fourth broad), then re-acquire
        run_field(0, L_GOOD, 5, 9);
        run_field(1, L_GOOD, 5, -1);
        run_field(0, L_GOOD, 5, -1);
        run_field(1, L_GOOD, 5, -1);

        // Truncated broad train; next field shows the FSM went back to VIDEO
        run_field(0, L_GOOD, 2, -1);
        run_field(1, L_GOOD, 5, -1);
        run_field(0, L_GOOD, 5, -1);
        run_field(1, L_GOOD, 5, -1);

        // Short field while locked, then recovery
        run_field(0, L_SHORT, 5, -1);
        run_field(1, L_GOOD, 5, -1);
        run_field(0, L_GOOD, 5, -1);
        run_field(1, L_GOOD, 5, -1);
        check("locked_before_timeout", locked, 1);

        // csync stops after one line pulse; timeout lands 82 cycles after it
        slot(K_LINE, 1'b1);
        for (int j = 0; j < 70; j++) begin
            tick(1'b1, 1'b1);
            if (j == 49) check("locked_pre_timeout", locked, 1);
            if (j == 50) begin
                check("locked_timeout", locked, 0);
                check("vsync_timeout", vsync_out, 1);
`ifdef VSYNC_LINE_COUNT_EN
                check("line_holds", line_number, hs_cnt);
`else
                check("line_holds", line_number, 0);
`endif
            end
        end
        m_state     = M_SEARCH;
        m_bcnt      = 0;
        m_good      = 0;
        m_have_prev = 1'b0;
        m_locked    = 1'b0;
        m_ever      = 1'b0;

        // From SEARCH the field type must not be latched
        run_field(0, L_GOOD, 5, -1);
        run_field(1, L_GOOD, 5, -1);
        run_field(0, L_GOOD, 5, -1);
        run_field(1, L_GOOD, 5, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
